// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
//   Receiver/deserializer for the single-wire serial link. One line bit is
//   sampled per clock. A frame is: start bit 1, marker bit 0, DATA_W data
//   bits LSB-first, then (if PARITY_EN) an even-parity bit. Each good word
//   is presented on a valid/ready output port.
//
// Handshake: dout_valid rises when a word is stored and stays high with
//   dout stable until an edge where dout_valid & dout_ready, at which point
//   the word is consumed. dout_ready may be driven freely; it never changes
//   dout or dout_valid combinationally.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din        serial line, idles at 0
//   dout       received word (holds its last value after acceptance)
//   dout_valid word available
//   dout_ready consumer accepts when high together with dout_valid
//   busy       a frame is in progress (state != IDLE)
//   ferr       1-cycle pulse: marker bit was 1 (treated as a new start bit)
//   perr       1-cycle pulse: parity mismatch, word dropped
//   ovr        1-cycle pulse: good word dropped, output still full
//   state_dbg  current FSM state (0 IDLE, 1 MARK, 2 DATA, 3 PAR)
// ---------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              ferr,
  output logic              perr,
  output logic              ovr,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                perr_q, perr_d;
  logic                ovr_q, ovr_d;
  logic                complete;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    par_d    = par_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    perr_d   = 1'b0;
    ovr_d    = 1'b0;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        if (din) state_d = MARK;
      end
      MARK: begin
        if (!din) begin
          state_d = DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
        end else begin
          // A 1 here is a framing error but also a valid new start bit,
          // so the FSM waits for a marker again.
          ferr_d = 1'b1;
        end
      end
      DATA: begin
        word_d[cnt_q] = din;
        par_d         = par_q ^ din;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          if (PARITY_EN) begin
            state_d = PAR;
          end else begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end
      end
      PAR: begin
        state_d = IDLE;
        if (par_q ^ din) perr_d = 1'b1;
        else             complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Output register. word_d already includes the bit sampled this cycle,
    // which matters for the no-parity case where the last data bit completes.
    if (complete) begin
      if (!valid_q || dout_ready) begin
        dout_d  = word_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign ferr       = ferr_q;
  assign perr       = perr_q;
  assign ovr        = ovr_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_rx
//   Directed bench for serial_frame_rx (DATA_W=8, PARITY_EN=1). Drivers
//   push expected words into exp_q; a negedge monitor pops and compares on
//   every accepted word and counts error-pulse cycles.
// ---------------------------------------------------------------------------
module tb_serial_frame_rx;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         din;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;
  logic         ferr;
  logic         perr;
  logic         ovr;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cyc = 0;
  int perr_cyc = 0;
  int ovr_cyc  = 0;

  logic [W-1:0] exp_q[$];

  serial_frame_rx #(.DATA_W(W), .PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .ferr       (ferr),
    .perr       (perr),
    .ovr        (ovr),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (ferr) ferr_cyc++;
    if (perr) perr_cyc++;
    if (ovr)  ovr_cyc++;
    if (dout_valid && dout_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", dout);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          n_fail++;
          $display("FAIL word: got %0h expected %0h", dout, e);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  // Start, marker, data LSB-first, even parity (optionally corrupted).
  // If rdy_last is set, dout_ready is raised just before the parity edge.
  task automatic send_frame(input logic [W-1:0] w, input logic flip, input logic rdy_last);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(w[i]);
    if (rdy_last) dout_ready = 1'b1;
    send_bit((^w) ^ flip);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b0;
    din        = 1'b0;
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout",  32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_pulses", {29'h0, ferr, perr, ovr}, 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst = 1'b1;
    send_bit(1'b0);

    // Good frame 0xA5, ready high.
    dout_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_bit(1'b1);
    check("busy_mid", 32'(busy), 32'h1);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) begin
      check("valid_early", 32'(dout_valid), 32'h0);
      send_bit(i == 0 || i == 2 || i == 5 || i == 7);
    end
    send_bit(1'b0);
    check("good_valid", 32'(dout_valid), 32'h1);
    check("good_dout",  32'(dout), 32'hA5);
    check("good_busy",  32'(busy), 32'h0);
    send_bit(1'b0);
    check("good_valid_drop", 32'(dout_valid), 32'h0);

    // Parity error on the same word.
    send_frame(8'hA5, 1'b1, 1'b0);
    check("perr_pulse", 32'(perr), 32'h1);
    check("perr_valid", 32'(dout_valid), 32'h0);
    check("perr_dout",  32'(dout), 32'hA5);
    repeat (2) send_bit(1'b0);
    check("perr_cycles", 32'(perr_cyc), 32'h1);
    check("perr_no_ferr", 32'(ferr_cyc), 32'h0);

    // Framing error: 1,1,0 then 0x3C.
    exp_q.push_back(8'h3C);
    send_bit(1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_dout", 32'(dout), 32'h3C);
    repeat (2) send_bit(1'b0);
    check("ferr_cycles", 32'(ferr_cyc), 32'h1);

    // Overrun: 0x11 then 0x22 back-to-back with ready low.
    dout_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    check("ovr_pulse", 32'(ovr), 32'h1);
    check("ovr_valid", 32'(dout_valid), 32'h1);
    check("ovr_dout",  32'(dout), 32'h11);
    send_bit(1'b0);
    check("ovr_cycles", 32'(ovr_cyc), 32'h1);
    dout_ready = 1'b1;
    send_bit(1'b0);
    check("ovr_accept_valid", 32'(dout_valid), 32'h0);
    check("ovr_accept_dout",  32'(dout), 32'h11);
    dout_ready = 1'b0;

    // Simultaneous accept of 0x11 and completion of 0x22.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);
    check("sim_valid", 32'(dout_valid), 32'h1);
    check("sim_dout",  32'(dout), 32'h22);
    send_bit(1'b0);
    check("sim_no_ovr", 32'(ovr_cyc), 32'h1);
    check("sim_valid_drop", 32'(dout_valid), 32'h0);

    // Reset mid-frame after 4 data bits.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_dout",  32'(dout), 32'h0);
    check("mid_rst_busy",  32'(busy), 32'h0);
    check("mid_rst_state", 32'(state_dbg), 32'h0);
    check("mid_rst_valid", 32'(dout_valid), 32'h0);
    din = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b0, 1'b0);
    check("ff_dout",  32'(dout), 32'hFF);
    check("ff_valid", 32'(dout_valid), 32'h1);
    repeat (3) send_bit(1'b0);

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    check("final_perr_cycles", 32'(perr_cyc), 32'h1);
    check("final_ferr_cycles", 32'(ferr_cyc), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
